// File: rtl/sb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// sb_tx_arbiter
//
// Round-robin arbiter that lets N_REQ LTSM substate requesters share a single
// sideband TX message port. One message is in flight at a time. Each message
// is followed by a one-cycle gap so the SB TX always sees valid drop between
// messages.
//
// Handshake (valid/ready):
//   SB_TX_msg_valid_o is the valid and SB_TX_msg_sendNextFlag_i is the ready.
//   A message transfers on a rising edge where both are high. While valid is
//   high, SB_TX_msg_o and SB_TX_dataBus_o are stable. Valid never drops
//   without a transfer, except on a SEND timeout or a reset. Ready is ignored
//   while valid is low. On the requester side, req_valid_i is a level request
//   and req_ack_o is a one-cycle pulse marking the transfer of that request.
//
// Ports:
//   clk_100MHz                - sole clock, rising edge
//   reset                     - synchronous, active-high
//   enable_i                  - allows new grants (in-flight message unaffected)
//   req_valid_i[N_REQ]        - per-requester send request
//   req_msg_i[N_REQ]          - per-requester sideband message
//   req_data_i[N_REQ]         - per-requester 64-bit payload
//   req_ack_o[N_REQ]          - one-cycle accept pulse to the owner
//   grant_o[N_REQ]            - one-hot current owner, zero when idle
//   busy_o                    - FSM not in IDLE
//   SB_TX_msg_o               - latched message to the SB TX
//   SB_TX_dataBus_o           - latched payload to the SB TX
//   SB_TX_msg_valid_o         - high exactly while in SEND
//   SB_TX_msg_sendNextFlag_i  - SB TX consumed the current message
//   timeout_o                 - one-cycle pulse when SEND times out
//   dbg_state                 - FSM state: 0 IDLE, 1 SEND, 2 GAP
// -----------------------------------------------------------------------------

typedef enum logic [2:0] {
   SB_MSG_NONE          = 3'd0,
   SBINIT_OUT_OF_RESET  = 3'd1,
   SBINIT_DONE_REQ      = 3'd2,
   SBINIT_DONE_RESP     = 3'd3,
   MBINIT_PARAM_REQ     = 3'd4,
   MBINIT_PARAM_RESP    = 3'd5,
   LINKINIT_ACTIVE_REQ  = 3'd6,
   LINKINIT_ACTIVE_RESP = 3'd7
} SB_msg_t;

module sb_tx_arbiter #(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = 800000
) (
   input  logic              clk_100MHz,
   input  logic              reset,
   input  logic              enable_i,
   input  logic [N_REQ-1:0]  req_valid_i,
   input  SB_msg_t           req_msg_i [N_REQ],
   input  logic [63:0]       req_data_i [N_REQ],
   output logic [N_REQ-1:0]  req_ack_o,
   output logic [N_REQ-1:0]  grant_o,
   output logic              busy_o,
   output SB_msg_t           SB_TX_msg_o,
   output logic [63:0]       SB_TX_dataBus_o,
   output logic              SB_TX_msg_valid_o,
   input  logic              SB_TX_msg_sendNextFlag_i,
   output logic              timeout_o,
   output logic [1:0]        dbg_state
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
   localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t           state;
   logic [PTR_W-1:0] rr_ptr;     // highest-priority requester for the next pick
   logic [PTR_W-1:0] owner;      // index of the requester currently granted
   logic [CNT_W-1:0] send_cnt;   // cycles spent in the current SEND

   logic             pick_found;
   logic [PTR_W-1:0] pick_idx;

   // Rotating priority search: take the first set request at or after rr_ptr,
   // wrapping modulo N_REQ.
   always_comb begin
      int               j;
      logic [PTR_W-1:0] j_idx;
      j          = 0;
      j_idx      = '0;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         j = int'(rr_ptr) + i;
         if (j >= N_REQ) begin
            j = j - N_REQ;
         end
         j_idx = PTR_W'(j);
         if (!pick_found && req_valid_i[j_idx]) begin
            pick_found = 1'b1;
            pick_idx   = j_idx;
         end
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state             <= ST_IDLE;
         rr_ptr            <= '0;
         owner             <= '0;
         send_cnt          <= '0;
         grant_o           <= '0;
         req_ack_o         <= '0;
         timeout_o         <= 1'b0;
         SB_TX_msg_valid_o <= 1'b0;
         SB_TX_msg_o       <= SB_MSG_NONE;
         SB_TX_dataBus_o   <= '0;
      end else begin
         // Ack and timeout are single-cycle pulses.
         req_ack_o <= '0;
         timeout_o <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (enable_i && pick_found) begin
                  owner             <= pick_idx;
                  grant_o           <= ONE_HOT0 << pick_idx;
                  SB_TX_msg_o       <= req_msg_i[pick_idx];
                  SB_TX_dataBus_o   <= req_data_i[pick_idx];
                  SB_TX_msg_valid_o <= 1'b1;
                  send_cnt          <= '0;
                  state             <= ST_SEND;
               end
            end

            ST_SEND: begin
               // A consumed message takes priority over a coincident timeout.
               // The requester's req_valid_i is deliberately not consulted
               // here: once latched, a message always runs to completion.
               if (SB_TX_msg_sendNextFlag_i || (send_cnt == CNT_LAST)) begin
                  if (SB_TX_msg_sendNextFlag_i) begin
                     req_ack_o <= grant_o;
                  end else begin
                     timeout_o <= 1'b1;
                  end
                  SB_TX_msg_valid_o <= 1'b0;
                  grant_o           <= '0;
                  rr_ptr            <= (owner == PTR_LAST) ? '0 : owner + 1'b1;
                  state             <= ST_GAP;
               end else begin
                  // Exit at CNT_LAST keeps the counter from ever wrapping.
                  send_cnt <= send_cnt + 1'b1;
               end
            end

            ST_GAP: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy_o    = (state != ST_IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sb_tx_arbiter
//
// Directed bench for sb_tx_arbiter (N_REQ=4, TIMEOUT_CYC=16). The bench moves
// one clock at a time with tick(), which returns 1 ns after the rising edge.
// Inputs are changed there and outputs are observed there. A negedge monitor
// checks that grant_o and req_ack_o stay one-hot-or-zero in every cycle.
// -----------------------------------------------------------------------------

module tb_sb_tx_arbiter;

   localparam int N  = 4;
   localparam int TO = 16;

   // clock / reset
   logic clk_100MHz = 1'b0;
   logic reset;
   always #5 clk_100MHz = ~clk_100MHz;

   // DUT signals
   logic          enable;
   logic [N-1:0]  req_valid;
   SB_msg_t       req_msg [N];
   logic [63:0]   req_data [N];
   logic [N-1:0]  req_ack;
   logic [N-1:0]  grant;
   logic          busy;
   SB_msg_t       tx_msg;
   logic [63:0]   tx_data;
   logic          tx_valid;
   logic          send_next;
   logic          timeout;
   logic [1:0]    dbg_state;

   sb_tx_arbiter #(
      .N_REQ       (N),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk_100MHz               (clk_100MHz),
      .reset                    (reset),
      .enable_i                 (enable),
      .req_valid_i              (req_valid),
      .req_msg_i                (req_msg),
      .req_data_i               (req_data),
      .req_ack_o                (req_ack),
      .grant_o                  (grant),
      .busy_o                   (busy),
      .SB_TX_msg_o              (tx_msg),
      .SB_TX_dataBus_o          (tx_data),
      .SB_TX_msg_valid_o        (tx_valid),
      .SB_TX_msg_sendNextFlag_i (send_next),
      .timeout_o                (timeout),
      .dbg_state                (dbg_state)
   );

   // scoreboard counters
   int n_pass  = 0;
   int n_total = 0;
   bit mon_en  = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_100MHz);
      #1;
   endtask

   // Structural invariants, sampled away from the active edge.
   always @(negedge clk_100MHz) begin
      if (mon_en) begin
         check("grant_onehot0", 64'($onehot0(grant)), 64'd1);
         check("ack_onehot0",   64'($onehot0(req_ack)), 64'd1);
      end
   end

   // Watchdog: the directed sequence is a few hundred cycles at most.
   initial begin
      #100us;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   // Messages/payloads the requesters present (restored after modifications).
   SB_msg_t     msg_pat  [N];
   logic [63:0] data_pat [N];

   initial begin
      int          ord [5];
      logic [N-1:0] g;
      int          bad;

      msg_pat[0]  = SBINIT_OUT_OF_RESET;
      msg_pat[1]  = SBINIT_DONE_REQ;
      msg_pat[2]  = MBINIT_PARAM_REQ;
      msg_pat[3]  = LINKINIT_ACTIVE_REQ;
      data_pat[0] = 64'h0123_4567_89AB_CDEF;
      data_pat[1] = 64'hFEDC_BA98_7654_3210;
      data_pat[2] = 64'h0000_0000_DEAD_BEEF;
      data_pat[3] = 64'hA5A5_5A5A_F0F0_0F0F;

      // ---- reset: outputs must be cleared even with live inputs ----
      reset     = 1'b1;
      enable    = 1'b1;
      req_valid = 4'b1111;
      send_next = 1'b0;
      for (int i = 0; i < N; i++) begin
         req_msg[i]  = msg_pat[i];
         req_data[i] = data_pat[i];
      end
      tick();
      tick();
      check("rst_valid",   64'(tx_valid),  64'd0);
      check("rst_grant",   64'(grant),     64'd0);
      check("rst_ack",     64'(req_ack),   64'd0);
      check("rst_busy",    64'(busy),      64'd0);
      check("rst_timeout", 64'(timeout),   64'd0);
      check("rst_data",    tx_data,        64'd0);
      check("rst_msg",     64'(tx_msg),    64'(SB_MSG_NONE));
      check("rst_state",   64'(dbg_state), 64'd0);
      req_valid = '0;
      reset     = 1'b0;
      mon_en    = 1'b1;
      tick();

      // ---- single request on requester 2, latency and hold ----
      req_valid = 4'b0100;                        // cycle 0
      tick();                                     // cycle 1
      check("t1_valid", 64'(tx_valid),  64'd1);
      check("t1_grant", 64'(grant),     64'b0100);
      check("t1_data",  tx_data,        64'h0000_0000_DEAD_BEEF);
      check("t1_msg",   64'(tx_msg),    64'(MBINIT_PARAM_REQ));
      check("t1_busy",  64'(busy),      64'd1);
      check("t1_state", 64'(dbg_state), 64'd1);
      req_data[2] = 64'h0;
      req_msg[2]  = SBINIT_DONE_RESP;
      tick();                                     // cycle 2
      check("t1_hold_data", tx_data,      64'h0000_0000_DEAD_BEEF);
      check("t1_hold_msg",  64'(tx_msg),  64'(MBINIT_PARAM_REQ));
      check("t1_no_ack",    64'(req_ack), 64'd0);
      tick();                                     // cycle 3
      check("t1_valid_c3", 64'(tx_valid), 64'd1);
      send_next = 1'b1;
      tick();                                     // cycle 4
      check("t1_ack",       64'(req_ack),   64'b0100);
      check("t1_valid_low", 64'(tx_valid),  64'd0);
      check("t1_gap_grant", 64'(grant),     64'd0);
      check("t1_gap_state", 64'(dbg_state), 64'd2);
      check("t1_gap_busy",  64'(busy),      64'd1);
      send_next   = 1'b0;
      req_valid   = '0;
      req_data[2] = data_pat[2];
      req_msg[2]  = msg_pat[2];
      tick();                                     // cycle 5
      check("t1_ack_pulse", 64'(req_ack),   64'd0);
      check("t1_idle",      64'(dbg_state), 64'd0);

      // ---- round robin from rr_ptr 0 with all four requesting ----
      reset = 1'b1;
      tick();
      reset     = 1'b0;
      req_valid = 4'b1111;
      ord = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
         g = 4'b0001 << ord[k];
         tick();
         check("rr_grant", 64'(grant),    64'(g));
         check("rr_valid", 64'(tx_valid), 64'd1);
         check("rr_data",  tx_data,       data_pat[ord[k]]);
         send_next = 1'b1;
         tick();
         check("rr_ack",       64'(req_ack),  64'(g));
         check("rr_gap_valid", 64'(tx_valid), 64'd0);
         check("rr_gap_grant", 64'(grant),    64'd0);
         send_next = 1'b0;
         tick();
         check("rr_idle_valid", 64'(tx_valid),  64'd0);
         check("rr_idle_state", 64'(dbg_state), 64'd0);
      end
      req_valid = '0;                             // rr_ptr is now 1

      // ---- enable low blocks new grants ----
      enable    = 1'b0;
      req_valid = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("en0_valid", 64'(tx_valid), 64'd0);
         check("en0_grant", 64'(grant),    64'd0);
         check("en0_busy",  64'(busy),     64'd0);
      end

      // ---- enable and request dropped mid-SEND: message still acked ----
      enable = 1'b1;
      tick();
      check("en_grant", 64'(grant), 64'b0010);
      check("en_data",  tx_data,    data_pat[1]);
      enable    = 1'b0;
      req_valid = '0;
      tick();
      check("en_drop_valid", 64'(tx_valid), 64'd1);
      check("en_drop_grant", 64'(grant),    64'b0010);
      tick();
      send_next = 1'b1;
      tick();
      check("en_drop_ack",   64'(req_ack),  64'b0010);
      check("en_drop_vlow",  64'(tx_valid), 64'd0);
      send_next = 1'b0;
      tick();                                     // IDLE, rr_ptr = 2

      // ---- sendNextFlag outside SEND is ignored ----
      enable    = 1'b1;
      send_next = 1'b1;
      tick();
      check("stray_ack0",  64'(req_ack), 64'd0);
      tick();
      check("stray_ack1",  64'(req_ack), 64'd0);
      check("stray_busy",  64'(busy),    64'd0);
      send_next = 1'b0;

      // ---- timeout: flag never returned ----
      req_valid = 4'b1100;
      tick();                                     // valid rises here
      check("to_grant", 64'(grant), 64'b0100);
      bad = 0;
      for (int k = 1; k < TO; k++) begin
         tick();
         if (tx_valid !== 1'b1 || timeout !== 1'b0 || req_ack !== '0) bad++;
      end
      check("to_send_hold", 64'(bad), 64'd0);
      tick();                                     // 16 cycles after valid rose
      check("to_pulse",  64'(timeout),   64'd1);
      check("to_no_ack", 64'(req_ack),   64'd0);
      check("to_vlow",   64'(tx_valid),  64'd0);
      check("to_state",  64'(dbg_state), 64'd2);
      tick();
      check("to_pulse_end", 64'(timeout), 64'd0);
      tick();
      check("to_next_grant", 64'(grant), 64'b1000);
      check("to_next_data",  tx_data,    data_pat[3]);
      send_next = 1'b1;
      tick();
      check("to_next_ack", 64'(req_ack), 64'b1000);
      send_next = 1'b0;
      req_valid = '0;
      tick();                                     // rr_ptr = 0

      // ---- flag on the final timeout cycle: ack wins ----
      req_valid = 4'b0001;
      tick();
      check("co_grant", 64'(grant), 64'b0001);
      for (int k = 1; k < TO; k++) begin
         tick();
      end
      check("co_still_valid", 64'(tx_valid), 64'd1);
      send_next = 1'b1;
      tick();
      check("co_ack",        64'(req_ack), 64'b0001);
      check("co_no_timeout", 64'(timeout), 64'd0);
      send_next = 1'b0;
      req_valid = '0;
      tick();                                     // rr_ptr = 1

      // ---- reset mid-SEND, held request regranted from index 0 ----
      req_valid = 4'b0101;
      tick();                                     // SEND cycle 1
      check("rs_grant_pre", 64'(grant), 64'b0100);
      tick();                                     // SEND cycle 2
      reset = 1'b1;
      tick();
      check("rs_valid",   64'(tx_valid), 64'd0);
      check("rs_grant",   64'(grant),    64'd0);
      check("rs_ack",     64'(req_ack),  64'd0);
      check("rs_timeout", 64'(timeout),  64'd0);
      check("rs_busy",    64'(busy),     64'd0);
      reset = 1'b0;
      tick();
      check("rs_regrant", 64'(grant), 64'b0001);
      check("rs_data",    tx_data,    data_pat[0]);
      send_next = 1'b1;
      tick();
      check("rs_ack_after", 64'(req_ack), 64'b0001);
      send_next = 1'b0;
      req_valid = '0;
      tick();
      tick();

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
